// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Bundle of the fetch-unit handshake signals: PC side, the
//               instruction-memory request/ack port and the decode hand-off.
//               slave  : the fetch unit's view
//               master : the surrounding core / memory / decode view
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if #(
  parameter int unsigned Data_Width = 32
);
  logic [Data_Width-1:0] PC;          // byte address from the PC register
  logic                  pc_valid;    // PC holds an address to fetch
  logic                  mem_req;     // read request to instruction memory
  logic [Data_Width-1:0] mem_addr;    // latched fetch address
  logic                  mem_ack;     // mem_rdata is valid this cycle
  logic [Data_Width-1:0] mem_rdata;   // instruction word from memory
  logic [Data_Width-1:0] Instr;       // fetched instruction (registered)
  logic                  instr_valid; // Instr valid for decode
  logic                  instr_ready; // decode accepts Instr this cycle
  logic                  pc_stall;    // PC must hold its value
  logic                  fetch_err;   // misaligned PC or memory timeout

  modport slave (
    input  PC, pc_valid, mem_ack, mem_rdata, instr_ready,
    output mem_req, mem_addr, Instr, instr_valid, pc_stall, fetch_err
  );

  modport master (
    output PC, pc_valid, mem_ack, mem_rdata, instr_ready,
    input  mem_req, mem_addr, Instr, instr_valid, pc_stall, fetch_err
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Samples the PC on a fetch request, runs a req/ack read against
//               variable-latency instruction memory, and holds the returned
//               word until decode accepts it. Stalls the PC while busy.
// Ports       : clk      - rising-edge clock
//               reset    - synchronous, active-high
//               fetch_io - instr_fetch_unit_if.slave (PC, memory, decode,
//                          pc_stall, fetch_err)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int unsigned Data_Width = 32,
  parameter int unsigned Timeout    = 15   // REQ cycles allowed without ack (1..255)
) (
  input  wire logic           clk,
  input  wire logic           reset,
  instr_fetch_unit_if.slave   fetch_io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Last counter value seen in REQ before giving up; counter starts at 0 so
  // this yields exactly Timeout request cycles.
  localparam logic [7:0] C_TIMEOUT_LAST = 8'(Timeout - 1);

  state_t                state_q,  state_d;
  logic [7:0]            cnt_q,    cnt_d;
  logic [Data_Width-1:0] addr_q,   addr_d;
  logic [Data_Width-1:0] instr_q,  instr_d;

  logic w_aligned;
  assign w_aligned = (fetch_io.PC[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;

    unique case (state_q)
      // IDLE and ERR share the fetch-launch rules.
      IDLE, ERR: begin
        if (fetch_io.pc_valid) begin
          if (w_aligned) begin
            state_d = REQ;
            addr_d  = fetch_io.PC;
            cnt_d   = 8'd0;
          end else begin
            state_d = ERR;
          end
        end
      end

      REQ: begin
        if (fetch_io.mem_ack) begin
          instr_d = fetch_io.mem_rdata;
          state_d = HOLD;
        end else begin
          if (cnt_q == C_TIMEOUT_LAST) begin
            state_d = ERR;
          end
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      HOLD: begin
        // Hand-off and next fetch launch happen in the same cycle (no bubble).
        if (fetch_io.instr_ready) begin
          if (!fetch_io.pc_valid) begin
            state_d = IDLE;
          end else if (w_aligned) begin
            state_d = REQ;
            addr_d  = fetch_io.PC;
            cnt_d   = 8'd0;
          end else begin
            state_d = ERR;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
    end
  end

  assign fetch_io.mem_req     = (state_q == REQ);
  assign fetch_io.mem_addr    = addr_q;
  assign fetch_io.Instr       = instr_q;
  assign fetch_io.instr_valid = (state_q == HOLD);
  assign fetch_io.fetch_err   = (state_q == ERR);
  // Only output with a combinational input path: decode back-pressure.
  assign fetch_io.pc_stall    = (state_q == REQ) |
                                ((state_q == HOLD) & ~fetch_io.instr_ready);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed bench for instr_fetch_unit with a transaction-level
//               reference model and hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam int DW = 32;
  localparam int TO = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.Data_Width(DW)) bus ();

  instr_fetch_unit #(.Data_Width(DW), .Timeout(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .fetch_io (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model (transaction level) ----------------
  // Activity: 0 nothing outstanding, 1 waiting on memory, 2 offering a word
  // to decode, 3 reporting an error.
  int          m_act    = 0;
  int          m_waited = 0;   // request cycles already spent without ack
  logic [31:0] m_addr   = '0;
  logic [31:0] m_instr  = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_act = 0; m_waited = 0; m_addr = '0; m_instr = '0;
    end else begin
      if (m_act == 1) begin
        if (bus.mem_ack) begin
          m_instr = bus.mem_rdata;
          m_act   = 2;
        end else begin
          m_waited = m_waited + 1;
          if (m_waited >= TO) m_act = 3;
        end
      end else if ((m_act == 0 || m_act == 3 || (m_act == 2 && bus.instr_ready))
                   && bus.pc_valid) begin
        if (bus.PC % 4 != 0) m_act = 3;
        else begin
          m_act = 1; m_addr = bus.PC; m_waited = 0;
        end
      end else if (m_act == 2 && bus.instr_ready) begin
        m_act = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("mdl_mem_req",     32'(bus.mem_req),     32'(m_act == 1));
    chk("mdl_instr_valid", 32'(bus.instr_valid), 32'(m_act == 2));
    chk("mdl_fetch_err",   32'(bus.fetch_err),   32'(m_act == 3));
    chk("mdl_pc_stall",    32'(bus.pc_stall),
        32'((m_act == 1) || (m_act == 2 && !bus.instr_ready)));
    chk("mdl_mem_addr",    bus.mem_addr, m_addr);
    chk("mdl_Instr",       bus.Instr,    m_instr);
  endtask

  task automatic settle(); @(negedge clk); check_model(); endtask
  task automatic adv();    @(posedge clk); #1;            endtask
  task automatic tick();   settle(); adv();               endtask

  task automatic all_zero(input string tag);
    chk({tag, "_mem_req"},     32'(bus.mem_req),     32'd0);
    chk({tag, "_mem_addr"},    bus.mem_addr,         32'd0);
    chk({tag, "_Instr"},       bus.Instr,            32'd0);
    chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_pc_stall"},    32'(bus.pc_stall),    32'd0);
    chk({tag, "_fetch_err"},   32'(bus.fetch_err),   32'd0);
  endtask

  int n_req;
  int lat;

  initial begin
    bus.PC = '0; bus.pc_valid = 0; bus.mem_ack = 0; bus.mem_rdata = '0;
    bus.instr_ready = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Reset state
    settle(); all_zero("rst");
    adv();

    // Minimum-latency fetch
    bus.PC = 32'h0040_0000; bus.pc_valid = 1; tick();
    bus.pc_valid = 0; bus.mem_ack = 1; bus.mem_rdata = 32'h2008_0005;
    settle();
    chk("t1_mem_req",  32'(bus.mem_req), 32'd1);
    chk("t1_mem_addr", bus.mem_addr, 32'h0040_0000);
    chk("t1_pc_stall", 32'(bus.pc_stall), 32'd1);
    adv();
    bus.mem_ack = 0; bus.mem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("t1_instr_valid", 32'(bus.instr_valid), 32'd1);
    chk("t1_Instr",       bus.Instr, 32'h2008_0005);
    adv();

    // Decode back-pressure for 3 cycles, then back-to-back fetch
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_Instr_stable", bus.Instr, 32'h2008_0005);
      chk("t3_pc_stall",     32'(bus.pc_stall), 32'd1);
      adv();
    end
    bus.instr_ready = 1; bus.pc_valid = 1; bus.PC = 32'h0040_0004;
    settle();
    chk("t3_stall_released", 32'(bus.pc_stall), 32'd0);
    adv();
    bus.instr_ready = 0; bus.pc_valid = 0;

    // Delayed ack: 4 cycles of wait, ack in the 5th request cycle
    n_req = 0; lat = -1;
    for (int k = 0; k < 12; k++) begin
      bus.mem_ack   = (k == 4);
      bus.mem_rdata = 32'h8C09_0000;
      settle();
      if (k == 0) chk("t3_b2b_addr", bus.mem_addr, 32'h0040_0004);
      if (bus.mem_req) begin
        n_req++;
        chk("t2_pc_stall", 32'(bus.pc_stall), 32'd1);
      end
      if (bus.instr_valid) begin lat = k; break; end
      adv();
    end
    chk("t2_req_cycles", 32'(n_req), 32'd5);
    chk("t2_valid_cycle", 32'(lat), 32'd5);
    chk("t2_Instr", bus.Instr, 32'h8C09_0000);
    bus.mem_ack = 0; bus.instr_ready = 1;
    adv();
    bus.instr_ready = 0;

    // Misaligned PC, then recovery with aligned PC
    bus.PC = 32'h0040_0002; bus.pc_valid = 1; tick();
    bus.pc_valid = 0;
    settle();
    chk("t4_fetch_err", 32'(bus.fetch_err), 32'd1);
    chk("t4_no_req",    32'(bus.mem_req),   32'd0);
    adv();
    tick(); tick();
    bus.PC = 32'h0040_000C; bus.pc_valid = 1; tick();
    bus.pc_valid = 0; bus.mem_ack = 1; bus.mem_rdata = 32'h3C01_1001;
    settle();
    chk("t4_err_cleared", 32'(bus.fetch_err), 32'd0);
    chk("t4_req",         32'(bus.mem_req),   32'd1);
    chk("t4_addr",        bus.mem_addr, 32'h0040_000C);
    adv();
    bus.mem_ack = 0; bus.instr_ready = 1;
    settle();
    chk("t4_Instr", bus.Instr, 32'h3C01_1001);
    adv();
    bus.instr_ready = 0;

    // Timeout with no ack
    bus.PC = 32'h0040_0010; bus.pc_valid = 1; tick();
    bus.pc_valid = 0;
    n_req = 0;
    for (int k = 0; k < 30; k++) begin
      settle();
      if (bus.mem_req) n_req++;
      if (bus.fetch_err) break;
      adv();
    end
    chk("t5_req_cycles", 32'(n_req), 32'd15);
    chk("t5_fetch_err",  32'(bus.fetch_err), 32'd1);
    bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF_FFFF;
    adv(); tick();
    settle();
    chk("t5_late_ack_valid", 32'(bus.instr_valid), 32'd0);
    chk("t5_late_ack_err",   32'(bus.fetch_err),   32'd1);
    bus.mem_ack = 0;
    adv();

    // Reset in the second request cycle
    bus.PC = 32'h0040_0014; bus.pc_valid = 1; tick();
    bus.pc_valid = 0; tick();
    reset = 1;
    settle();
    chk("t6_in_req", 32'(bus.mem_req), 32'd1);
    adv();
    reset = 0; bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678;
    settle(); all_zero("t6");
    adv();
    settle();
    chk("t6_ack_ignored", 32'(bus.instr_valid), 32'd0);
    bus.mem_ack = 0;
    adv();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
